// File: rtl/pe_result_drain_if.sv
// Bundle between the PE array result side, the drain block and the downstream stream.
// master = drain block, slave = PE array / downstream consumer side.
interface pe_result_drain_if #(
  parameter int PE_NUM = 8,
  parameter int ACC_W  = 42,
  parameter int OUT_W  = 16,
  parameter int IDX_W  = 3
);
  logic [PE_NUM-1:0][ACC_W-1:0] y_in;
  logic [PE_NUM-1:0]            done_in;
  logic signed [OUT_W-1:0]      out_data;
  logic [IDX_W-1:0]             out_idx;
  logic                         out_valid;
  logic                         out_ready;
  logic                         out_last;
  logic                         out_sat;
  logic                         busy;
  logic                         block_done;
  logic                         err_drop;
  logic                         dbg_state;

  // Stream: a beat transfers on a clock edge where out_valid && out_ready.
  // out_valid never depends on out_ready, and once raised it stays high with
  // out_data/out_idx/out_last/out_sat stable until that beat is accepted.
  modport master (
    input  y_in, done_in, out_ready,
    output out_data, out_idx, out_valid, out_last, out_sat,
           busy, block_done, err_drop, dbg_state
  );

  modport slave (
    output y_in, done_in, out_ready,
    input  out_data, out_idx, out_valid, out_last, out_sat,
           busy, block_done, err_drop, dbg_state
  );
endinterface

// File: rtl/pe_result_drain.sv
// Collects per-lane PE accumulator results, then requantizes (round, shift,
// saturate) and streams them out in lane order over a valid/ready interface.
module pe_result_drain #(
  parameter int PE_NUM = 8,
  parameter int DW     = 16,
  parameter int N      = 786,
  parameter int ACC_W  = 2*DW + $clog2(N),
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 8,
  localparam int IDX_W = (PE_NUM > 1) ? $clog2(PE_NUM) : 1
) (
  input  logic               clk,
  input  logic               rst,
  pe_result_drain_if.master  bus
);

  typedef enum logic {COLLECT = 1'b0, DRAIN = 1'b1} state_e;

  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(PE_NUM - 1);
  localparam logic signed [ACC_W:0] ONE     = 1;
  localparam logic signed [ACC_W:0] RND     =
    (SHIFT > 0) ? (ONE <<< ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
  localparam logic signed [ACC_W:0] SAT_MAX = (ONE <<< (OUT_W - 1)) - ONE;
  localparam logic signed [ACC_W:0] SAT_MIN = -(ONE <<< (OUT_W - 1));

  state_e                  state_q, state_d;
  logic [PE_NUM-1:0]       mask_q, mask_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic signed [ACC_W-1:0] lane_q [PE_NUM];
  logic signed [ACC_W-1:0] lane_d [PE_NUM];
  logic                    block_done_q, block_done_d;
  logic                    err_drop_q, err_drop_d;
  logic                    last_beat;

  logic signed [ACC_W-1:0] sel;
  logic signed [ACC_W:0]   ext, rounded, shifted;
  logic signed [OUT_W-1:0] q_data;
  logic                    q_sat;

  assign last_beat = (idx_q == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= COLLECT;
      mask_q       <= '0;
      idx_q        <= '0;
      block_done_q <= 1'b0;
      err_drop_q   <= 1'b0;
      for (int i = 0; i < PE_NUM; i++) lane_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      idx_q        <= idx_d;
      block_done_q <= block_done_d;
      err_drop_q   <= err_drop_d;
      for (int i = 0; i < PE_NUM; i++) lane_q[i] <= lane_d[i];
    end
  end

  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    idx_d        = idx_q;
    block_done_d = 1'b0;
    err_drop_d   = err_drop_q;
    for (int i = 0; i < PE_NUM; i++) lane_d[i] = lane_q[i];

    case (state_q)
      COLLECT: begin
        // Captured lanes are masked, so a level-held done_in is harmless.
        for (int i = 0; i < PE_NUM; i++) begin
          if (bus.done_in[i] && !mask_q[i]) begin
            lane_d[i] = $signed(bus.y_in[i]);
            mask_d[i] = 1'b1;
          end
        end
        if (&mask_d) begin
          state_d = DRAIN;
          idx_d   = '0;
        end
      end
      DRAIN: begin
        if (|bus.done_in) err_drop_d = 1'b1;
        if (bus.out_ready) begin
          if (last_beat) begin
            state_d      = COLLECT;
            mask_d       = '0;
            idx_d        = '0;
            block_done_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // One extra bit of headroom keeps the rounding add from overflowing.
  always_comb begin
    sel     = lane_q[idx_q];
    ext     = {sel[ACC_W-1], sel};
    rounded = ext + RND;
    shifted = rounded >>> SHIFT;
    q_sat   = 1'b0;
    q_data  = shifted[OUT_W-1:0];
    if (shifted > SAT_MAX) begin
      q_data = SAT_MAX[OUT_W-1:0];
      q_sat  = 1'b1;
    end else if (shifted < SAT_MIN) begin
      q_data = SAT_MIN[OUT_W-1:0];
      q_sat  = 1'b1;
    end
  end

  assign bus.out_valid  = (state_q == DRAIN);
  assign bus.busy       = (state_q == DRAIN);
  assign bus.out_idx    = idx_q;
  assign bus.out_data   = (state_q == DRAIN) ? q_data : '0;
  assign bus.out_last   = (state_q == DRAIN) && last_beat;
  assign bus.out_sat    = (state_q == DRAIN) && q_sat;
  assign bus.block_done = block_done_q;
  assign bus.err_drop   = err_drop_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_pe_result_drain.sv
// Directed bench for pe_result_drain: full-block drain, staggered completion
// with stalls, requantization corners, dropped done and asynchronous reset.
module tb_pe_result_drain;
  localparam int PE_NUM = 8;
  localparam int ACC_W  = 42;
  localparam int OUT_W  = 16;
  localparam int IDX_W  = 3;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  pe_result_drain_if #(.PE_NUM(PE_NUM), .ACC_W(ACC_W), .OUT_W(OUT_W), .IDX_W(IDX_W)) bus ();

  pe_result_drain #(
    .PE_NUM(PE_NUM), .DW(16), .N(786), .OUT_W(OUT_W), .SHIFT(8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.done_in   = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < PE_NUM; i++) bus.y_in[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", bus.out_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", bus.busy); end
    checks++; if (bus.out_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %0b expected 0", bus.out_last); end
    checks++; if (bus.out_sat !== 1'b0) begin errors++; $display("FAIL reset_sat: got %0b expected 0", bus.out_sat); end
    checks++; if (bus.block_done !== 1'b0) begin errors++; $display("FAIL reset_block_done: got %0b expected 0", bus.block_done); end
    checks++; if (bus.err_drop !== 1'b0) begin errors++; $display("FAIL reset_err_drop: got %0b expected 0", bus.err_drop); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_all_done;
    for (int i = 0; i < PE_NUM; i++) bus.y_in[i] = ACC_W'(i * 256);
    bus.out_ready = 1'b1;
    bus.done_in   = '1;
    tick();
    bus.done_in = '0;
    for (int k = 0; k < PE_NUM; k++) begin
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL all_valid k=%0d: got %0b expected 1", k, bus.out_valid); end
      checks++; if (bus.out_idx !== IDX_W'(k)) begin errors++; $display("FAIL all_idx: got %0d expected %0d", bus.out_idx, k); end
      checks++; if (bus.out_data !== OUT_W'(k)) begin errors++; $display("FAIL all_data k=%0d: got %0d expected %0d", k, bus.out_data, k); end
      checks++; if (bus.out_last !== (k == PE_NUM - 1)) begin errors++; $display("FAIL all_last k=%0d: got %0b expected %0b", k, bus.out_last, k == PE_NUM - 1); end
      tick();
    end
    checks++; if (bus.block_done !== 1'b1) begin errors++; $display("FAIL all_block_done: got %0b expected 1", bus.block_done); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL all_busy_after: got %0b expected 0", bus.busy); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL all_valid_after: got %0b expected 0", bus.out_valid); end
    tick();
    checks++; if (bus.block_done !== 1'b0) begin errors++; $display("FAIL all_block_done_pulse: got %0b expected 0", bus.block_done); end
  endtask

  task automatic test_staggered;
    int ord [8] = '{3, 7, 1, 6, 2, 5, 4, 0};
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int exp_idx;
    int cyc;
    bit rdy;
    for (int i = 0; i < PE_NUM; i++) bus.y_in[i] = ACC_W'((i + 10) * 256);
    bus.done_in = '0;
    for (int s = 0; s < PE_NUM; s++) begin
      bus.done_in[ord[s]] = 1'b1;
      tick();
      if (s < PE_NUM - 1) begin
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stag_early_valid s=%0d: got %0b expected 0", s, bus.out_valid); end
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stag_early_valid2 s=%0d: got %0b expected 0", s, bus.out_valid); end
      end
    end
    bus.done_in = '0;
    exp_idx = 0;
    cyc = 0;
    while (exp_idx < PE_NUM && cyc < 64) begin
      rdy = pat[cyc % 4];
      bus.out_ready = rdy;
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL stag_valid cyc=%0d: got %0b expected 1", cyc, bus.out_valid); end
      checks++; if (bus.out_idx !== IDX_W'(exp_idx)) begin errors++; $display("FAIL stag_idx cyc=%0d: got %0d expected %0d", cyc, bus.out_idx, exp_idx); end
      checks++; if (bus.out_data !== OUT_W'(exp_idx + 10)) begin errors++; $display("FAIL stag_data cyc=%0d: got %0d expected %0d", cyc, bus.out_data, exp_idx + 10); end
      checks++; if (bus.out_last !== (exp_idx == PE_NUM - 1)) begin errors++; $display("FAIL stag_last cyc=%0d: got %0b expected %0b", cyc, bus.out_last, exp_idx == PE_NUM - 1); end
      tick();
      if (rdy) exp_idx++;
      cyc++;
    end
    checks++; if (exp_idx !== PE_NUM) begin errors++; $display("FAIL stag_timeout: got %0d beats expected %0d", exp_idx, PE_NUM); end
    checks++; if (bus.block_done !== 1'b1) begin errors++; $display("FAIL stag_block_done: got %0b expected 1", bus.block_done); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL stag_busy_after: got %0b expected 0", bus.busy); end
    bus.out_ready = 1'b1;
    tick();
  endtask

  task automatic test_requant;
    int y_tab [8]   = '{384, 383, -384, -385, 1 << 30, -(1 << 30), 32767 * 256, 0};
    int d_tab [8]   = '{2, 1, -1, -2, 32767, -32768, 32767, 0};
    bit s_tab [8]   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < PE_NUM; i++) bus.y_in[i] = ACC_W'(y_tab[i]);
    bus.out_ready = 1'b1;
    bus.done_in   = '1;
    tick();
    bus.done_in = '0;
    for (int k = 0; k < PE_NUM; k++) begin
      checks++; if (bus.out_data !== OUT_W'(d_tab[k])) begin errors++; $display("FAIL rq_data y=%0d: got %0d expected %0d", y_tab[k], bus.out_data, d_tab[k]); end
      checks++; if (bus.out_sat !== s_tab[k]) begin errors++; $display("FAIL rq_sat y=%0d: got %0b expected %0b", y_tab[k], bus.out_sat, s_tab[k]); end
      tick();
    end
    tick();
  endtask

  task automatic test_err_drop;
    for (int i = 0; i < PE_NUM; i++) bus.y_in[i] = ACC_W'(i * 256);
    bus.out_ready = 1'b1;
    bus.done_in   = '1;
    tick();
    bus.done_in = '0;
    for (int k = 0; k < PE_NUM; k++) begin
      checks++; if (bus.out_data !== OUT_W'(k)) begin errors++; $display("FAIL drop_data k=%0d: got %0d expected %0d", k, bus.out_data, k); end
      bus.done_in = (k == 2) ? 8'h20 : 8'h00;
      tick();
    end
    bus.done_in = '0;
    checks++; if (bus.err_drop !== 1'b1) begin errors++; $display("FAIL drop_flag: got %0b expected 1", bus.err_drop); end
    checks++; if (bus.block_done !== 1'b1) begin errors++; $display("FAIL drop_block_done: got %0b expected 1", bus.block_done); end
    bus.y_in[5] = ACC_W'(99 * 256);
    bus.done_in = 8'hDF;
    tick();
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL drop_lane5_not_captured: got %0b expected 0", bus.out_valid); end
    checks++; if (bus.err_drop !== 1'b1) begin errors++; $display("FAIL drop_sticky: got %0b expected 1", bus.err_drop); end
    bus.done_in = 8'hFF;
    tick();
    bus.done_in = '0;
    for (int k = 0; k < PE_NUM; k++) begin
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL drop2_valid k=%0d: got %0b expected 1", k, bus.out_valid); end
      checks++; if (bus.out_data !== OUT_W'((k == 5) ? 99 : k)) begin errors++; $display("FAIL drop2_data k=%0d: got %0d expected %0d", k, bus.out_data, (k == 5) ? 99 : k); end
      tick();
    end
    checks++; if (bus.err_drop !== 1'b1) begin errors++; $display("FAIL drop_sticky_end: got %0b expected 1", bus.err_drop); end
    tick();
  endtask

  task automatic test_reset_mid_drain;
    for (int i = 0; i < PE_NUM; i++) bus.y_in[i] = ACC_W'(i * 256);
    bus.out_ready = 1'b1;
    bus.done_in   = '1;
    tick();
    bus.done_in = '0;
    for (int k = 0; k < 4; k++) begin
      checks++; if (bus.out_idx !== IDX_W'(k)) begin errors++; $display("FAIL rm_idx: got %0d expected %0d", bus.out_idx, k); end
      tick();
    end
    bus.out_ready = 1'b0;
    tick();
    checks++; if (bus.out_idx !== IDX_W'(4)) begin errors++; $display("FAIL rm_stall_idx: got %0d expected 4", bus.out_idx); end
    checks++; if (bus.out_data !== OUT_W'(4)) begin errors++; $display("FAIL rm_stall_data: got %0d expected 4", bus.out_data); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rm_async_valid: got %0b expected 0", bus.out_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rm_async_busy: got %0b expected 0", bus.busy); end
    checks++; if (bus.err_drop !== 1'b0) begin errors++; $display("FAIL rm_err_clear: got %0b expected 0", bus.err_drop); end
    #2 rst = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rm_no_stale1: got %0b expected 0", bus.out_valid); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rm_no_stale2: got %0b expected 0", bus.out_valid); end
    for (int i = 0; i < PE_NUM; i++) bus.y_in[i] = ACC_W'((i + 20) * 256);
    bus.done_in = '1;
    tick();
    bus.done_in = '0;
    for (int k = 0; k < PE_NUM; k++) begin
      checks++; if (bus.out_idx !== IDX_W'(k)) begin errors++; $display("FAIL rm_new_idx: got %0d expected %0d", bus.out_idx, k); end
      checks++; if (bus.out_data !== OUT_W'(k + 20)) begin errors++; $display("FAIL rm_new_data k=%0d: got %0d expected %0d", k, bus.out_data, k + 20); end
      tick();
    end
    checks++; if (bus.block_done !== 1'b1) begin errors++; $display("FAIL rm_block_done: got %0b expected 1", bus.block_done); end
  endtask

  initial begin
    test_reset();
    test_all_done();
    test_staggered();
    test_requant();
    test_err_drop();
    test_reset_mid_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pe_result_drain.md
Name: pe_result_drain

Overview:
- Consumer on the output side of the PE array.
- Captures each lane's accumulator result `y_in[i]` when that lane's `done_in[i]` asserts. Once every lane has reported, it requantizes the results (round, shift, saturate) and streams them out one per cycle over a valid/ready interface in lane order.
- Sits between the PE array and the writeback/next-layer input buffer, decoupling the array's parallel completion from a narrow downstream stream.

Parameters:
- PE_NUM, 8, number of PE lanes.
- DW, 16, PE operand width.
- N, 786, dot-product length.
- ACC_W, 2*DW+$clog2(N), accumulator width (derived; 42 at defaults).
- OUT_W, 16, signed output width.
- SHIFT, 8, right shift applied during requantization (0..ACC_W-1).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- y_in  in  PE_NUM x ACC_W signed  per-lane accumulator results
- done_in  in  PE_NUM  per-lane completion flags (level or pulse)
- out_data  out  OUT_W signed  requantized result
- out_idx  out  $clog2(PE_NUM)  lane index of out_data
- out_valid  out  1  out_data/out_idx/out_last/out_sat valid
- out_ready  in  1  downstream accepts
- out_last  out  1  high on lane PE_NUM-1 beat
- out_sat  out  1  current beat was saturated
- busy  out  1  high in DRAIN
- block_done  out  1  one-cycle pulse after final beat accepted
- err_drop  out  1  sticky: done_in seen while in DRAIN

Behaviour:
- One clock domain, clk. Reset is asynchronous and active-high on rst.
- Reset values:
  - state=COLLECT, capture mask=0, idx=0, lane buffers=0
  - out_valid=0, out_last=0, out_sat=0, busy=0, block_done=0, err_drop=0
- COLLECT:
  - On each edge, for each lane i with done_in[i]=1 and mask[i]=0: buf[i]<=y_in[i] and mask[i]<=1.
  - Lanes already captured ignore further done_in, so level-held done is safe.
  - If the next mask is all ones, state<=DRAIN and idx<=0 on that same edge.
  - Latency: final done_in sampled at edge t gives out_valid=1 in the cycle after t.
- DRAIN:
  - out_valid=1, busy=1, out_idx=idx.
  - out_data=sat(round(buf[idx])). out_last=(idx==PE_NUM-1).
  - A beat is accepted on an edge with out_valid&&out_ready. On acceptance, idx<=idx+1.
  - If the accepted beat has out_last: state<=COLLECT, mask<=0, idx<=0, block_done<=1 for exactly the next cycle.
  - While out_ready=0, out_data/out_idx/out_last/out_sat hold stable. out_valid never drops without acceptance.
- done_in during DRAIN is ignored (not captured); any done_in bit=1 in DRAIN sets err_drop, cleared only by rst.
- done_in on the same edge that leaves DRAIN is also ignored. Capture resumes the cycle after.
- Requantization, in ACC_W+1 bits signed:
  - r = y + (SHIFT>0 ? 2^(SHIFT-1) : 0), then arithmetic shift right by SHIFT (round half toward +inf).
  - Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. out_sat=1 when clamped.
  - The rounding add never overflows, because of the extra bit.
- No combinational path from out_ready to out_valid/out_data; all outputs derive from registers.
- rst mid-DRAIN or mid-COLLECT: immediate return to reset values; partial captures are discarded.

Test Plan:
- All done_in=8'hFF in one cycle, y_in[i]=i*256, out_ready=1:
  - out_valid in the next cycle; 8 consecutive beats with out_data=0..7 and out_idx=0..7.
  - out_last only on idx 7; block_done 1 cycle after the idx-7 acceptance; busy low thereafter.
- Staggered done (lane 3 first, lane 0 last, 2 cycles apart, done held high), out_ready toggling 1,0,0,1:
  - Streaming starts only after lane 0 is captured.
  - Data held stable during stalls; no beat lost or duplicated.
- Rounding at SHIFT=8:
  - y=384 -> 2; y=383 -> 1.
  - y=-384 -> -1; y=-385 -> -2.
  - out_sat=0 in all cases.
- Saturation:
  - y=2^30 -> 32767 with out_sat=1.
  - y=-2^30 -> -32768 with out_sat=1.
  - y=32767*256 -> 32767 with out_sat=0.
- Assert done_in[5] during DRAIN:
  - err_drop=1 and stays high; the current block's output is unaffected.
  - The next block captures lane 5 only on a fresh done_in after returning to COLLECT.
- Assert rst during beat 4 of DRAIN with out_ready=0:
  - out_valid=0 and busy=0 immediately (asynchronous).
  - After release, no stale beats; a new all-done block streams from idx 0.
